// File: rtl/dir_input.sv
// Debounced four-way direction input: 2-flop synchronizers, press/release debounce FSM, one-cycle pulses.
// Define DIR_COMBO_EN to also accept orthogonal two-button diagonals (n/s plus e/w) as simultaneous pulses.
module dir_input #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  input  logic btn_s,
  input  logic btn_e,
  input  logic btn_w,
  output logic n,
  output logic s,
  output logic e,
  output logic w,
  output logic busy
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SETTLE     = 3'd1,
    FIRE       = 3'd2,
    HOLD       = 3'd3,
    REL_SETTLE = 3'd4
  } state_t;

  logic [3:0]       sync1_r;
  logic [3:0]       b_r;
  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [3:0]       snap_r;
  logic [3:0]       snap_next_s;
  logic [3:0]       pulse_r;
  logic [3:0]       pulse_next_s;
  logic             busy_r;
  logic             busy_next_s;

  // Anything other than a legal single direction (or allowed diagonal) yields no pulse.
  function automatic logic [3:0] pulse_decode(input logic [3:0] snap);
    logic [3:0] dec;
    dec = 4'b0000;
    case (snap)
      4'b1000, 4'b0100, 4'b0010, 4'b0001: dec = snap;
`ifdef DIR_COMBO_EN
      4'b1010, 4'b1001, 4'b0110, 4'b0101: dec = snap;
`endif
      default: dec = 4'b0000;
    endcase
    return dec;
  endfunction

  // Two-flop synchronizer for the raw buttons, vector ordered {n,s,e,w}.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 4'b0000;
      b_r     <= 4'b0000;
    end else begin
      sync1_r <= {btn_n, btn_s, btn_e, btn_w};
      b_r     <= sync1_r;
    end
  end

  // Next-state, counter, snapshot, pulse and busy decode.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    snap_next_s  = snap_r;
    case (state_r)
      IDLE: begin
        if (b_r != 4'b0000) begin
          snap_next_s  = b_r;
          cnt_next_s   = CNT_ZERO;
          state_next_s = SETTLE;
        end else begin
          state_next_s = IDLE;
        end
      end
      SETTLE: begin
        if (b_r == 4'b0000) begin
          state_next_s = IDLE;
        end else if (b_r != snap_r) begin
          snap_next_s = b_r;
          cnt_next_s  = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_next_s = FIRE;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      FIRE: begin
        state_next_s = HOLD;
      end
      HOLD: begin
        if (b_r == 4'b0000) begin
          cnt_next_s   = CNT_ZERO;
          state_next_s = REL_SETTLE;
        end else begin
          state_next_s = HOLD;
        end
      end
      REL_SETTLE: begin
        if (b_r != 4'b0000) begin
          state_next_s = HOLD;
        end else if (cnt_r == CNT_LAST) begin
          state_next_s = IDLE;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = CNT_ZERO;
        snap_next_s  = 4'b0000;
      end
    endcase

    // Pulses load on entry to FIRE and clear on the following edge.
    if (state_next_s == FIRE) begin
      pulse_next_s = pulse_decode(snap_r);
    end else begin
      pulse_next_s = 4'b0000;
    end
    busy_next_s = (state_next_s != IDLE);
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      snap_r  <= 4'b0000;
      pulse_r <= 4'b0000;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      snap_r  <= snap_next_s;
      pulse_r <= pulse_next_s;
      busy_r  <= busy_next_s;
    end
  end

  assign n    = pulse_r[3];
  assign s    = pulse_r[2];
  assign e    = pulse_r[1];
  assign w    = pulse_r[0];
  assign busy = busy_r;

endmodule

// File: tb/tb_dir_input.sv
// Self-checking bench for dir_input: directed scenarios plus random presses against a run-length reference model.
// Expectations for diagonal presses follow DIR_COMBO_EN.
module tb_dir_input;

  localparam int D = 4;
`ifdef DIR_COMBO_EN
  localparam int COMBO = 1;
`else
  localparam int COMBO = 0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] raw;
  logic       n, s, e, w, busy;

  int vec_cnt;
  int err_cnt;
  int pcnt [4];

  // Reference model state: sync delay line, press run length, release run length.
  logic [3:0] m_sync1, m_sync2, m_last, m_pulse;
  bit         m_armed, m_skip, m_busy;
  int         m_run, m_zrun;

  dir_input #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .btn_n (raw[3]),
    .btn_s (raw[2]),
    .btn_e (raw[1]),
    .btn_w (raw[0]),
    .n     (n),
    .s     (s),
    .e     (e),
    .w     (w),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_pulse(input logic [3:0] b);
    if ($countones(b) == 1) return b;
`ifdef DIR_COMBO_EN
    if ($countones(b[3:2]) == 1 && $countones(b[1:0]) == 1) return b;
`endif
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_sync1 = 4'b0000; m_sync2 = 4'b0000; m_last = 4'b0000; m_pulse = 4'b0000;
    m_armed = 1'b1; m_skip = 1'b0; m_busy = 1'b0;
    m_run = 0; m_zrun = 0;
  endtask

  // A press fires once the same nonzero value has been seen D+1 edges in a row;
  // re-arming needs D+1 zero samples, ignoring the edge right after firing.
  task automatic model_step(input logic [3:0] r, input logic rst);
    logic [3:0] b;
    if (rst) begin
      model_reset();
      return;
    end
    b = m_sync2;
    m_sync2 = m_sync1;
    m_sync1 = r;
    m_pulse = 4'b0000;
    if (m_armed) begin
      if (b == 4'b0000) m_run = 0;
      else if (m_run > 0 && b == m_last) m_run++;
      else m_run = 1;
      m_last = b;
      if (m_run == D + 1) begin
        m_pulse = ref_pulse(b);
        m_armed = 1'b0; m_skip = 1'b1; m_zrun = 0; m_run = 0;
      end
    end else if (m_skip) begin
      m_skip = 1'b0;
    end else if (b == 4'b0000) begin
      m_zrun++;
      if (m_zrun == D + 1) begin
        m_armed = 1'b1; m_run = 0;
      end
    end else begin
      m_zrun = 0;
    end
    m_busy = !(m_armed && m_run == 0);
  endtask

  task automatic tick(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      model_step(raw, reset);
      #1;
      check("cycle", 32'({n, s, e, w, busy}), 32'({m_pulse, m_busy}));
      pcnt[3] += int'(n); pcnt[2] += int'(s); pcnt[1] += int'(e); pcnt[0] += int'(w);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) pcnt[i] = 0;
  endtask

  initial begin
    int first_k;
    vec_cnt = 0; err_cnt = 0;
    clear_counts();
    model_reset();
    raw   = 4'b0000;
    reset = 1'b1;
    #2;
    check("reset_async", 32'({n, s, e, w, busy}), 32'd0);
    tick(3);
    check("reset_state", 32'({n, s, e, w, busy}), 32'd0);
    reset = 1'b0;
    tick(2);

    // btn_e held: pulse exactly after edge 6, busy from edge 2.
    clear_counts();
    raw = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check("e_latency", 32'({n, s, e, w}), (k == 6) ? 32'h2 : 32'h0);
      check("e_busy", 32'(busy), 32'(k >= 2));
    end
    raw = 4'b0000;
    tick(12);
    check("e_count", 32'(pcnt[1]), 32'd1);
    check("e_idle", 32'(busy), 32'd0);

    // btn_s chatter every 2 cycles never fires.
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      raw = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      tick(2);
    end
    raw = 4'b0000;
    tick(12);
    check("chatter_pulses", 32'(pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3]), 32'd0);
    check("chatter_idle", 32'(busy), 32'd0);

    // Long hold then re-press: exactly two w pulses.
    clear_counts();
    raw = 4'b0001; tick(50);
    raw = 4'b0000; tick(12);
    raw = 4'b0001; tick(15);
    raw = 4'b0000; tick(12);
    check("w_twice", 32'(pcnt[0]), 32'd2);
    check("w_only", 32'(pcnt[1] + pcnt[2] + pcnt[3]), 32'd0);

    // Diagonal s+e, then opposing n+s.
    clear_counts();
    raw = 4'b0110; tick(12);
    raw = 4'b0000; tick(12);
    check("combo_s", 32'(pcnt[2]), 32'(COMBO));
    check("combo_e", 32'(pcnt[1]), 32'(COMBO));
    clear_counts();
    raw = 4'b1100; tick(12);
    raw = 4'b0000; tick(12);
    check("oppose_ns", 32'(pcnt[3] + pcnt[2]), 32'd0);

    // Reset during a btn_n press aborts it; the held button fires afresh.
    clear_counts();
    raw = 4'b1000;
    tick(5);
    reset = 1'b1;
    model_reset();
    #1;
    check("mid_reset", 32'({n, s, e, w, busy}), 32'd0);
    tick(3);
    reset = 1'b0;
    first_k = -1;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (n && first_k < 0) first_k = k;
    end
    check("rst_n_edge", 32'(first_k), 32'd6);
    raw = 4'b0000;
    tick(12);
    check("rst_n_count", 32'(pcnt[3]), 32'd1);

    // Random presses of random length.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0:       raw = 4'b0000;
        1:       raw = 4'(1 << $urandom_range(0, 3));
        2:       raw = 4'($urandom_range(0, 15));
        default: raw = 4'(1 << $urandom_range(0, 3));
      endcase
      tick($urandom_range(1, 12));
    end
    raw = 4'b0000;
    tick(15);
    check("final_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/dir_input.md
DIR_INPUT -- requirements
Module: dir_input

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable synchronized cycles required before a press or release is accepted (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have ports btn_n, btn_s, btn_e, btn_w, input, 1 bit each, raw asynchronous active-high pushbuttons.
REQ-005 The block SHALL have ports n, s, e, w, output, 1 bit each, registered one-cycle direction pulses for the room state machine.
REQ-006 The block SHALL have port busy, output, 1 bit, high whenever the controller is not in IDLE.

Function
REQ-007 Each button SHALL pass through a 2-flop synchronizer; the synchronized vector is b = {n,s,e,w}.
REQ-008 The controller SHALL have states IDLE, SETTLE, FIRE, HOLD, REL_SETTLE and a counter cnt sized for DEBOUNCE_CYCLES-1.
REQ-009 IDLE: b nonzero -> capture snap = b, cnt = 0, go SETTLE; else stay.
REQ-010 SETTLE: b zero -> IDLE; b nonzero and b != snap -> snap = b, cnt = 0, stay; b == snap and cnt == DEBOUNCE_CYCLES-1 -> FIRE; otherwise cnt increments.
REQ-011 FIRE SHALL last exactly one cycle then go HOLD; pulse registers load on entry to FIRE and clear on exit, so every pulse is exactly one cycle wide.
REQ-012 Pulse rule: snap with exactly one bit set -> the matching output pulses; any other snap -> no pulse (press rejected, FIRE/HOLD still traversed).
REQ-013 HOLD: b zero -> cnt = 0, go REL_SETTLE; else stay, no pulses regardless of changes in b.
REQ-014 REL_SETTLE: b nonzero -> HOLD; b zero and cnt == DEBOUNCE_CYCLES-1 -> IDLE; otherwise cnt increments.
REQ-015 Latency: raw input settled before edge E0 and held SHALL produce a pulse high from edge E0+DEBOUNCE_CYCLES+2 to edge E0+DEBOUNCE_CYCLES+3.
REQ-016 One physical press SHALL produce at most one pulse event; a new event requires full release-debounce back to IDLE.
REQ-017 Glitches shorter than DEBOUNCE_CYCLES during SETTLE SHALL restart the count and never produce a pulse.
REQ-018 busy SHALL be the registered decode of state != IDLE.

Reset
REQ-019 reset high SHALL immediately force synchronizer flops to 0, state IDLE, cnt 0, snap 0, n/s/e/w 0, busy 0.
REQ-020 Reset asserted mid-press SHALL abort any pending pulse; a button still held after reset release is treated as a fresh press and fires per REQ-015.

Configuration
REQ-021 Macro DIR_COMBO_EN defined: snap with exactly two orthogonal bits (one of n/s plus one of e/w) SHALL pulse both outputs in the same cycle; opposing pairs (n+s, e+w) and three or more bits are rejected.
REQ-022 DIR_COMBO_EN undefined: only single-bit snaps pulse, per REQ-012; combo logic is not compiled.

Verification
REQ-023 DEBOUNCE_CYCLES=4, btn_e held from before edge 0 -> e high exactly between edges 6 and 7, n/s/w 0, busy high from edge 2.
REQ-024 DEBOUNCE_CYCLES=4, btn_s toggling every 2 cycles for 20 cycles then low -> no pulse on any output, busy returns 0.
REQ-025 btn_w held 50 cycles, released, pressed again after release settles -> exactly two one-cycle w pulses.
REQ-026 btn_s+btn_e pressed together -> with DIR_COMBO_EN s and e pulse in the same cycle; without it no pulse; btn_n+btn_s -> no pulse in both builds.
REQ-027 reset pulsed at edge 4 of a btn_n press with DEBOUNCE_CYCLES=4 -> n 0 through reset; n pulses once 6 edges after reset deasserts.
